// File: rtl/rv32i_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Opcode values match the ID-stage decoder so encode/decode stay in lockstep.
package rv32i_enc_pkg;

  typedef enum logic [3:0] {
    OP_R     = 4'd0,
    OP_I     = 4'd1,
    OP_LD    = 4'd2,
    OP_S     = 4'd3,
    OP_B     = 4'd4,
    OP_JAL   = 4'd5,
    OP_JALR  = 4'd6,
    OP_LUI   = 4'd7,
    OP_AUIPC = 4'd8
  } op_class_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [3:0]  op_class;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/rv32i_imm_packer.sv
// Scatters a byte-offset immediate into its RV32I instruction bit positions (+ range flag with RV32I_ENC_CHECK_EN).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module rv32i_imm_packer
  import rv32i_enc_pkg::*;
(
  input  logic [3:0]  op_class,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [31:0] imm,
  output logic [31:0] imm_field
`ifdef RV32I_ENC_CHECK_EN
  , output logic      imm_bad
`endif
);

  logic is_shift;
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);

  always_comb begin
    imm_field = '0;
    case (op_class)
      OP_I: begin
        if (is_shift) imm_field = {1'b0, alt, 5'b0, imm[4:0], 20'b0};
        else          imm_field = {imm[11:0], 20'b0};
      end
      OP_LD, OP_JALR:   imm_field = {imm[11:0], 20'b0};
      OP_S:             imm_field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      OP_B:             imm_field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      OP_JAL:           imm_field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      OP_LUI, OP_AUIPC: imm_field = {imm[31:12], 12'b0};
      default:          imm_field = '0;
    endcase
  end

`ifdef RV32I_ENC_CHECK_EN
  // A value fits an N-bit signed field when all bits above N-1 equal the sign bit.
  logic fits12, fits13, fits21;
  assign fits12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits21 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    imm_bad = 1'b0;
    case (op_class)
      OP_I:                 imm_bad = is_shift ? (|imm[31:5]) : !fits12;
      OP_LD, OP_S, OP_JALR: imm_bad = !fits12;
      OP_B:                 imm_bad = !fits13 || imm[0];
      OP_JAL:               imm_bad = !fits21 || imm[0];
      OP_LUI, OP_AUIPC:     imm_bad = |imm[11:0];
      default:              imm_bad = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Encodes decoded RV32I fields into 32-bit instruction words; range checking with RV32I_ENC_CHECK_EN.
// Latency: 2 edges from input accept to instr_o when the FIFO is empty; 1/cycle throughput.
// Backpressure: out_ready_i low fills the FIFO, then S1 holds one entry and in_ready_o drops.
module rv32i_instr_encoder
  import rv32i_enc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_class_i,
  input  logic [2:0]       funct3_i,
  input  logic             alt_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [31:0]      imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      instr_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] enc_cnt_o,
  output logic [CNT_W-1:0] ill_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  fields_t        s1;
  logic           s1_valid, s1_move, fifo_full, push, pop;
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [31:0]    mem [DEPTH];
  logic [31:0]    imm_field, enc, entry_instr;
  logic [CNT_W-1:0] enc_cnt;

  assign pop        = out_valid_o && out_ready_i;
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s1_move    = s1_valid && (!fifo_full || pop);
  assign push       = s1_move;
  assign in_ready_o = !s1_valid || s1_move;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_valid_i && in_ready_o) begin
      s1_valid <= 1'b1;
      s1       <= '{op_class: op_class_i, funct3: funct3_i, alt: alt_i,
                    rd: rd_i, rs1: rs1_i, rs2: rs2_i, imm: imm_i};
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

`ifdef RV32I_ENC_CHECK_EN
  logic imm_bad, f3_bad, s1_illegal;
`endif

  rv32i_imm_packer u_packer (
    .op_class  (s1.op_class),
    .funct3    (s1.funct3),
    .alt       (s1.alt),
    .imm       (s1.imm),
    .imm_field (imm_field)
`ifdef RV32I_ENC_CHECK_EN
    , .imm_bad (imm_bad)
`endif
  );

  always_comb begin
    enc = NOP_INSTR;
    case (s1.op_class)
      OP_R:     enc = {1'b0, s1.alt, 5'b0, s1.rs2, s1.rs1, s1.funct3, s1.rd, OPC_OP};
      OP_I:     enc = imm_field | {12'b0, s1.rs1, s1.funct3, s1.rd, OPC_OP_IMM};
      OP_LD:    enc = imm_field | {12'b0, s1.rs1, s1.funct3, s1.rd, OPC_LOAD};
      OP_S:     enc = imm_field | {7'b0, s1.rs2, s1.rs1, s1.funct3, 5'b0, OPC_STORE};
      OP_B:     enc = imm_field | {7'b0, s1.rs2, s1.rs1, s1.funct3, 5'b0, OPC_BRANCH};
      OP_JAL:   enc = imm_field | {20'b0, s1.rd, OPC_JAL};
      OP_JALR:  enc = imm_field | {12'b0, s1.rs1, F3_JALR, s1.rd, OPC_JALR};
      OP_LUI:   enc = imm_field | {20'b0, s1.rd, OPC_LUI};
      OP_AUIPC: enc = imm_field | {20'b0, s1.rd, OPC_AUIPC};
      default:  enc = NOP_INSTR;
    endcase
  end

`ifdef RV32I_ENC_CHECK_EN
  always_comb begin
    f3_bad = 1'b0;
    case (s1.op_class)
      OP_LD:   f3_bad = s1.funct3 inside {3'b011, 3'b110, 3'b111};
      OP_S:    f3_bad = s1.funct3 > 3'b010;
      OP_B:    f3_bad = s1.funct3 inside {3'b010, 3'b011};
      OP_JALR: f3_bad = s1.funct3 != F3_JALR;
      default: f3_bad = 1'b0;
    endcase
  end

  assign s1_illegal  = imm_bad || f3_bad || (s1.op_class > OP_AUIPC);
  assign entry_instr = s1_illegal ? NOP_INSTR : enc;
`else
  assign entry_instr = enc;
`endif

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= entry_instr;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      enc_cnt <= '0;
    end else begin
      if (push) wr_ptr  <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr  <= rd_ptr + (AW+1)'(1);
      if (push) enc_cnt <= enc_cnt + CNT_W'(1);
    end
  end

  // Head outputs are gated by valid so reset and empty both present zeros.
  assign out_valid_o = (wr_ptr != rd_ptr);
  assign instr_o     = out_valid_o ? mem[rd_ptr[AW-1:0]] : '0;
  assign enc_cnt_o   = enc_cnt;

`ifdef RV32I_ENC_CHECK_EN
  logic             ill_mem [DEPTH];
  logic [CNT_W-1:0] ill_cnt;

  always_ff @(posedge clk_i) begin
    if (push) ill_mem[wr_ptr[AW-1:0]] <= s1_illegal;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                          ill_cnt <= '0;
    else if (push && s1_illegal && !(&ill_cnt)) ill_cnt <= ill_cnt + CNT_W'(1);
  end

  assign illegal_o = out_valid_o && ill_mem[rd_ptr[AW-1:0]];
  assign ill_cnt_o = ill_cnt;
`else
  assign illegal_o = 1'b0;
  assign ill_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: directed vectors, backpressure, async reset
// and a randomized stream scored against an ISA-format reference model.
`timescale 1ns/1ps
module tb_rv32i_instr_encoder;
  import rv32i_enc_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [3:0] op_class = '0;
  logic [2:0] funct3 = '0;
  logic alt = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] instr;
  logic illegal;
  logic [CNT_W-1:0] enc_cnt, ill_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_class_i(op_class), .funct3_i(funct3), .alt_i(alt),
    .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .instr_o(instr), .illegal_o(illegal),
    .enc_cnt_o(enc_cnt), .ill_cnt_o(ill_cnt)
  );

  // ---- ISA instruction formats ----
  function automatic logic [31:0] fmt_r(logic [6:0] f7, logic [4:0] b, logic [4:0] a,
                                        logic [2:0] f3, logic [4:0] d, logic [6:0] opc);
    return {f7, b, a, f3, d, opc};
  endfunction
  function automatic logic [31:0] fmt_i(logic [11:0] i, logic [4:0] a, logic [2:0] f3,
                                        logic [4:0] d, logic [6:0] opc);
    return {i, a, f3, d, opc};
  endfunction
  function automatic logic [31:0] fmt_s(logic [11:0] i, logic [4:0] b, logic [4:0] a,
                                        logic [2:0] f3, logic [6:0] opc);
    return {i[11:5], b, a, f3, i[4:0], opc};
  endfunction
  function automatic logic [31:0] fmt_b(logic [12:0] i, logic [4:0] b, logic [4:0] a,
                                        logic [2:0] f3, logic [6:0] opc);
    return {i[12], i[10:5], b, a, f3, i[4:1], i[11], opc};
  endfunction
  function automatic logic [31:0] fmt_u(logic [31:0] i, logic [4:0] d, logic [6:0] opc);
    return {i[31:12], d, opc};
  endfunction
  function automatic logic [31:0] fmt_j(logic [20:0] i, logic [4:0] d, logic [6:0] opc);
    return {i[20], i[10:1], i[11], i[19:12], d, opc};
  endfunction

  // Reference: returns {illegal, instr} for one set of fields.
  function automatic logic [32:0] ref_model(logic [3:0] cls, logic [2:0] f3, logic a,
                                            logic [4:0] d, logic [4:0] s1r, logic [4:0] s2r,
                                            logic [31:0] im);
    logic [31:0] w;
    bit bad;
    int v;
    bit out12;
    v = $signed(im);
    out12 = (v < -2048) || (v > 2047);
    bad = 1'b0;
    w = 32'h00000013;
    case (cls)
      4'd0: w = fmt_r({1'b0, a, 5'b0}, s2r, s1r, f3, d, 7'h33);
      4'd1: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          w = fmt_i({1'b0, a, 5'b0, im[4:0]}, s1r, f3, d, 7'h13);
          bad = im > 32'd31;
        end else begin
          w = fmt_i(im[11:0], s1r, f3, d, 7'h13);
          bad = out12;
        end
      end
      4'd2: begin w = fmt_i(im[11:0], s1r, f3, d, 7'h03); bad = out12 || f3 == 3'd3 || f3 >= 3'd6; end
      4'd3: begin w = fmt_s(im[11:0], s2r, s1r, f3, 7'h23); bad = out12 || f3 > 3'd2; end
      4'd4: begin
        w = fmt_b(im[12:0], s2r, s1r, f3, 7'h63);
        bad = (v < -4096) || (v > 4094) || (im[0] == 1'b1) || f3 == 3'd2 || f3 == 3'd3;
      end
      4'd5: begin
        w = fmt_j(im[20:0], d, 7'h6f);
        bad = (v < -1048576) || (v > 1048574) || (im[0] == 1'b1);
      end
      4'd6: begin w = fmt_i(im[11:0], s1r, 3'b000, d, 7'h67); bad = out12 || f3 != 3'd0; end
      4'd7: begin w = fmt_u(im, d, 7'h37); bad = im[11:0] != 12'd0; end
      4'd8: begin w = fmt_u(im, d, 7'h17); bad = im[11:0] != 12'd0; end
      default: begin w = 32'h00000013; bad = 1'b1; end
    endcase
`ifdef RV32I_ENC_CHECK_EN
    if (bad) w = 32'h00000013;
    return {bad, w};
`else
    return {1'b0, w};
`endif
  endfunction

  task automatic drive_fields(logic [3:0] c, logic [2:0] f, logic a, logic [4:0] d,
                              logic [4:0] s1r, logic [4:0] s2r, logic [31:0] im);
    op_class = c; funct3 = f; alt = a; rd = d; rs1 = s1r; rs2 = s2r; imm = im;
  endtask

  task automatic rand_fields();
    int mode;
    int sv;
    mode = $urandom_range(0, 3);
`ifdef RV32I_ENC_CHECK_EN
    op_class = 4'($urandom_range(0, 10));
`else
    op_class = 4'($urandom_range(0, 8));
`endif
    funct3 = 3'($urandom); alt = 1'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case (mode)
      0: begin sv = int'($urandom_range(0, 4200)) - 2100; imm = 32'(sv); end
      1: begin sv = 2 * (int'($urandom_range(0, 5000)) - 2500); imm = 32'(sv); end
      2: imm = {$urandom} & 32'hFFFFF000;
      default: imm = $urandom;
    endcase
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    checks++; if (enc_cnt !== '0 || ill_cnt !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", enc_cnt, ill_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    do_reset();
  endtask

  // Send one item with an empty FIFO; it must appear exactly two edges later.
  task automatic test_single(string name, logic [3:0] c, logic [2:0] f, logic a, logic [4:0] d,
                             logic [4:0] s1r, logic [4:0] s2r, logic [31:0] im, logic [31:0] expv);
    out_ready = 1'b1;
    drive_fields(c, f, a, d, s1r, s2r, im);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early: out_valid got %b expected 0", name, out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || instr !== expv) begin
      errors++; $display("FAIL %s: got valid=%b instr=%h expected valid=1 instr=%h", name, out_valid, instr, expv);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    test_single("addi",  OP_I,   3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093);
    test_single("sw",    OP_S,   3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423);
    test_single("beq",   OP_B,   3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h00208463);
    test_single("lui",   OP_LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7);
    test_single("jal",   OP_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         32'h008000EF);
    test_single("srai",  OP_I,   3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,         32'h40315093);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_fields(OP_R, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    alt = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || instr !== 32'h002081B3) begin errors++; $display("FAIL b2b_add: got %b/%h expected 1/002081B3", out_valid, instr); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || instr !== 32'h402081B3) begin errors++; $display("FAIL b2b_sub: got %b/%h expected 1/402081B3", out_valid, instr); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] expv [DEPTH+2];
    int acc, popped;
    bit dropped;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) expv[k] = 32'(ref_model(OP_I, 3'd0, 1'b0, 5'(k + 1), 5'd2, 5'd0, 32'(k * 7)));
    acc = 0; dropped = 1'b0;
    for (int cyc = 0; cyc < 12 && !dropped; cyc++) begin
      drive_fields(OP_I, 3'd0, 1'b0, 5'(acc + 1), 5'd2, 5'd0, 32'(acc * 7));
      in_valid = 1'b1;
      #1;
      if (in_ready) acc++; else dropped = 1'b1;
      if (!dropped) begin @(posedge clk); #1; end
    end
    in_valid = 1'b0;
    checks++; if (!dropped || acc != DEPTH + 1) begin errors++; $display("FAIL bp_accepted: got %0d dropped=%b expected %0d dropped=1", acc, dropped, DEPTH + 1); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || instr !== expv[0]) begin errors++; $display("FAIL bp_head_hold: got %b/%h expected 1/%h", out_valid, instr, expv[0]); end
    out_ready = 1'b1;
    popped = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid) begin
        checks++;
        if (popped >= DEPTH + 1 || instr !== expv[popped]) begin
          errors++; $display("FAIL bp_order: item %0d got %h expected %h", popped, instr, (popped < DEPTH + 2) ? expv[popped] : 32'h0);
        end
        popped++;
      end
      @(posedge clk); #1;
    end
    checks++; if (popped != DEPTH + 1) begin errors++; $display("FAIL bp_drain: got %0d items expected %0d", popped, DEPTH + 1); end
    checks++; if (enc_cnt !== CNT_W'(DEPTH + 1)) begin errors++; $display("FAIL bp_enc_cnt: got %0d expected %0d", enc_cnt, DEPTH + 1); end
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [32:0] m;
    do_reset();
    out_ready = 1'b1;
    drive_fields(OP_B, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    m = ref_model(OP_B, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
`ifdef RV32I_ENC_CHECK_EN
    checks++; if (instr !== 32'h00000013 || illegal !== 1'b1) begin errors++; $display("FAIL ill_b_odd: got %h/%b expected 00000013/1", instr, illegal); end
    checks++; if (ill_cnt !== CNT_W'(1)) begin errors++; $display("FAIL ill_cnt: got %0d expected 1", ill_cnt); end
`else
    checks++; if (instr !== m[31:0] || illegal !== 1'b0) begin errors++; $display("FAIL trunc_b_odd: got %h/%b expected %h/0", instr, illegal, m[31:0]); end
    checks++; if (ill_cnt !== '0) begin errors++; $display("FAIL ill_cnt_tied: got %0d expected 0", ill_cnt); end
`endif
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [32:0] exp_q [$];
    logic [32:0] front;
    int n_acc, n_ill;
    bit hold;
    do_reset();
    n_acc = 0; n_ill = 0; hold = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 9) < 7);
        rand_fields();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_spurious: got %h with nothing expected", instr);
        end else begin
          front = exp_q.pop_front();
          if ({illegal, instr} !== front) begin
            errors++; $display("FAIL rnd_item: got %b/%h expected %b/%h", illegal, instr, front[32], front[31:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        front = ref_model(op_class, funct3, alt, rd, rs1, rs2, imm);
        exp_q.push_back(front);
        n_acc++;
        if (front[32]) n_ill++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      #1;
      if (out_valid) begin
        checks++;
        front = exp_q.pop_front();
        if ({illegal, instr} !== front) begin
          errors++; $display("FAIL rnd_drain: got %b/%h expected %b/%h", illegal, instr, front[32], front[31:0]);
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_timeout: %0d items never emitted", exp_q.size()); end
    checks++; if (enc_cnt !== CNT_W'(n_acc)) begin errors++; $display("FAIL rnd_enc_cnt: got %0d expected %0d", enc_cnt, n_acc); end
    checks++; if (ill_cnt !== CNT_W'(n_ill)) begin errors++; $display("FAIL rnd_ill_cnt: got %0d expected %0d", ill_cnt, n_ill); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    drive_fields(OP_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    checks++; if (out_valid !== 1'b1 || enc_cnt !== CNT_W'(2)) begin errors++; $display("FAIL mid_prefill: got %b/%0d expected 1/2", out_valid, enc_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL mid_reset_out: got %b/%h expected 0/00000000", out_valid, instr); end
    checks++; if (enc_cnt !== '0 || ill_cnt !== '0) begin errors++; $display("FAIL mid_reset_cnt: got %0d/%0d expected 0/0", enc_cnt, ill_cnt); end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_release: got %b expected 0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
